decimal_merge: RTL and testbench



---
 rtl/decimal_merge.sv | 193 +++++++++++++++++++
 tb/tb_decimal_merge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/decimal_merge.sv
// ----------------------------------------------------------------------------
// decimal_merge
// Converts a two-digit BCD value (tens, units) into a binary count by adding
// ten once per enabled cycle, then adding the units digit and range checking
// the result against MAX_VAL. Used to load decimal phase durations into the
// traffic-light countdown timers.
//
// Optional feature (macro DECIMAL_MERGE_SAT_EN):
//   defined   : an out-of-range result is clamped to MAX_VAL with sat=1, valid=1
//   undefined : an out-of-range result gives err=1, count=0; sat is tied to 0
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   en     in   enable; low stalls the accumulation
//   start  in   conversion request, sampled only when idle
//   tens   in   [3:0] BCD tens digit
//   units  in   [3:0] BCD units digit
//   busy   out  high while accumulating and in the completion cycle
//   done   out  one-cycle completion pulse
//   valid  out  count holds a good result
//   err    out  invalid digit or out-of-range result
//   sat    out  result was clamped to MAX_VAL
//   count  out  [OUT_W-1:0] binary result
// ----------------------------------------------------------------------------
module decimal_merge #(
   parameter int OUT_W   = 7,
   parameter int MAX_VAL = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [3:0]       tens,
   input  logic [3:0]       units,
   output logic             busy,
   output logic             done,
   output logic             valid,
   output logic             err,
   output logic             sat,
   output logic [OUT_W-1:0] count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [31:0]      MAX_VAL_W = MAX_VAL;
   localparam logic [OUT_W-1:0] MAX_CNT   = MAX_VAL_W[OUT_W-1:0];

   state_t           state_r;
   state_t           state_next_s;
   logic [6:0]       acc_r;
   logic [3:0]       tens_rem_r;
   logic [3:0]       units_l_r;
   logic [6:0]       r_s;
   logic [OUT_W-1:0] r_cnt_s;
   logic             over_s;
   logic             digits_ok_s;
`ifdef DECIMAL_MERGE_SAT_EN
   logic             sat_r;
`endif

   // A BCD digit is legal only in the range 0..9.
   function automatic logic digit_ok(input logic [3:0] d);
      return (d <= 4'd9);
   endfunction

   // acc is at most 90 and units_l at most 9, so 7 bits never overflow.
   assign r_s         = acc_r + {3'd0, units_l_r};
   assign r_cnt_s     = OUT_W'(r_s);
   assign over_s      = ({25'd0, r_s} > MAX_VAL_W);
   assign digits_ok_s = digit_ok(tens) & digit_ok(units);

`ifdef DECIMAL_MERGE_SAT_EN
   assign sat = sat_r;
`else
   assign sat = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; start is honoured in IDLE regardless of en.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (digits_ok_s) begin
                  state_next_s = ACCUM;
               end else begin
                  state_next_s = DONE;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         ACCUM: begin
            if (en && (tens_rem_r == 4'd0)) begin
               state_next_s = DONE;
            end else begin
               state_next_s = ACCUM;
            end
         end
         DONE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs; busy/done follow the next state so they
   // line up with the state the FSM is in during the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r      <= 7'd0;
         tens_rem_r <= 4'd0;
         units_l_r  <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         valid      <= 1'b0;
         err        <= 1'b0;
         count      <= '0;
`ifdef DECIMAL_MERGE_SAT_EN
         sat_r      <= 1'b0;
`endif
      end else begin
         busy <= (state_next_s != IDLE);
         done <= (state_next_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  // Any accepted start clears the previous result.
                  valid <= 1'b0;
                  count <= '0;
`ifdef DECIMAL_MERGE_SAT_EN
                  sat_r <= 1'b0;
`endif
                  if (digits_ok_s) begin
                     units_l_r  <= units;
                     tens_rem_r <= tens;
                     acc_r      <= 7'd0;
                     err        <= 1'b0;
                  end else begin
                     err        <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (en) begin
                  if (tens_rem_r != 4'd0) begin
                     acc_r      <= acc_r + 7'd10;
                     tens_rem_r <= tens_rem_r - 4'd1;
                  end else if (over_s) begin
`ifdef DECIMAL_MERGE_SAT_EN
                     count <= MAX_CNT;
                     valid <= 1'b1;
                     err   <= 1'b0;
                     sat_r <= 1'b1;
`else
                     count <= '0;
                     valid <= 1'b0;
                     err   <= 1'b1;
`endif
                  end else begin
                     count <= r_cnt_s;
                     valid <= 1'b1;
                     err   <= 1'b0;
                  end
               end
            end
            DONE: begin
               acc_r <= acc_r;
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decimal_merge.sv
// ----------------------------------------------------------------------------
// tb_decimal_merge
// Self-checking bench for decimal_merge. Expected results come from the
// decimal value tens*10+units and the latency rule (tens+2 plus stalled
// cycles, or 1 for an invalid digit), independent of the RTL structure.
// ----------------------------------------------------------------------------
module tb_decimal_merge;

   localparam int OUT_W   = 7;
   localparam int MAX_VAL = 31;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             start;
   logic [3:0]       tens;
   logic [3:0]       units;
   logic             busy;
   logic             done;
   logic             valid;
   logic             err;
   logic             sat;
   logic [OUT_W-1:0] count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decimal_merge #(.OUT_W(OUT_W), .MAX_VAL(MAX_VAL)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .start (start),
      .tens  (tens),
      .units (units),
      .busy  (busy),
      .done  (done),
      .valid (valid),
      .err   (err),
      .sat   (sat),
      .count (count)
   );

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; en = 1'b1; tens = 4'd0; units = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, valid, err, sat, count} !== {5'b00000, {OUT_W{1'b0}}}) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b done=%b valid=%b err=%b sat=%b count=%0d want all 0",
                  busy, done, valid, err, sat, count);
      end
      rst = 1'b0;
   endtask

   // One conversion: start in cycle 0, en low for s_len cycles from s_at,
   // an ignored extra start at cycle restart_at (0 = none), observe tail
   // cycles past done (0 = return right at done for back-to-back use).
   task automatic run_conv(input logic [3:0] t, input logic [3:0] u,
                           input int s_at, input int s_len, input int restart_at,
                           input int tail, input string name);
      int   ti, ui, r, exp_done, done_cyc, n_done, stall;
      bit   dig_ok, busy_bad, exp_busy;
      logic [OUT_W-1:0] exp_c, got_c;
      logic exp_v, exp_e, exp_s, got_v, got_e, got_s;
      ti = int'(t); ui = int'(u);
      dig_ok = (ti <= 9) && (ui <= 9);
      r = ti * 10 + ui;
      stall = dig_ok ? s_len : 0;
      exp_done = dig_ok ? (ti + 2 + stall) : 1;
      if (!dig_ok) begin
         exp_c = '0; exp_v = 1'b0; exp_e = 1'b1; exp_s = 1'b0;
      end else if (r <= MAX_VAL) begin
         exp_c = OUT_W'(r); exp_v = 1'b1; exp_e = 1'b0; exp_s = 1'b0;
      end else begin
`ifdef DECIMAL_MERGE_SAT_EN
         exp_c = OUT_W'(MAX_VAL); exp_v = 1'b1; exp_e = 1'b0; exp_s = 1'b1;
`else
         exp_c = '0; exp_v = 1'b0; exp_e = 1'b1; exp_s = 1'b0;
`endif
      end
      done_cyc = -1; n_done = 0; busy_bad = 1'b0;
      got_c = '0; got_v = 1'b0; got_e = 1'b0; got_s = 1'b0;

      // cycle 0: request; en is irrelevant while idle
      @(posedge clk); #1;
      start = 1'b1; tens = t; units = u; en = 1'(($urandom_range(0, 1)));
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = k;
               got_c = count; got_v = valid; got_e = err; got_s = sat;
            end
         end
         exp_busy = (k <= exp_done);
         if (busy !== exp_busy) busy_bad = 1'b1;
         if (done_cyc >= 0 && tail > 0 && k == done_cyc + tail) begin
            total++;
            if ({count, valid, err, sat} !== {exp_c, exp_v, exp_e, exp_s}) begin
               bad++;
               $display("FAIL %s_hold got count=%0d v=%b e=%b s=%b want count=%0d v=%b e=%b s=%b",
                        name, count, valid, err, sat, exp_c, exp_v, exp_e, exp_s);
            end
         end
         // digits scrambled after acceptance must not matter
         start = (k == restart_at) && (k <= exp_done);
         tens  = 4'($urandom_range(0, 15));
         units = 4'($urandom_range(0, 15));
         en    = !(dig_ok && k >= s_at && k < s_at + s_len);
         if (done_cyc >= 0 && k >= done_cyc + tail) break;
      end
      start = 1'b0; en = 1'b1;

      total++;
      if (done_cyc < 0) begin
         bad++;
         $display("FAIL %s_timeout got no done pulse within 80 cycles want done in cycle %0d",
                  name, exp_done);
      end else begin
         if (done_cyc != exp_done) begin
            bad++;
            $display("FAIL %s_latency got done in cycle %0d want cycle %0d", name, done_cyc, exp_done);
         end
         total++;
         if (got_c !== exp_c) begin
            bad++;
            $display("FAIL %s_count got %0d want %0d", name, got_c, exp_c);
         end
         total++;
         if ({got_v, got_e, got_s} !== {exp_v, exp_e, exp_s}) begin
            bad++;
            $display("FAIL %s_flags got v=%b e=%b s=%b want v=%b e=%b s=%b",
                     name, got_v, got_e, got_s, exp_v, exp_e, exp_s);
         end
         total++;
         if (n_done != 1) begin
            bad++;
            $display("FAIL %s_pulses got %0d done pulses want 1", name, n_done);
         end
      end
      total++;
      if (busy_bad) begin
         bad++;
         $display("FAIL %s_busy got busy outside cycles 1..%0d want busy exactly there", name, exp_done);
      end
   endtask

   task automatic test_basic();
      run_conv(4'd2, 4'd5, 1, 0, 2, 3, "t25");
      run_conv(4'd0, 4'd7, 1, 0, 0, 3, "t07");
      run_conv(4'd3, 4'd1, 1, 0, 0, 3, "t31_max");
   endtask

   task automatic test_range();
      run_conv(4'd4, 4'd2, 1, 0, 0, 3, "t42_over");
      run_conv(4'd9, 4'd9, 1, 0, 3, 3, "t99_over");
   endtask

   task automatic test_invalid();
      run_conv(4'd1, 4'd12, 1, 0, 1, 4, "bad_units");
      run_conv(4'd10, 4'd3, 1, 0, 1, 4, "bad_tens");
   endtask

   task automatic test_stall();
      run_conv(4'd2, 4'd0, 2, 3, 0, 3, "stall20");
      run_conv(4'd0, 4'd4, 1, 2, 0, 3, "stall_final");
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(posedge clk); #1;
      start = 1'b1; tens = 4'd2; units = 4'd5; en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if ({busy, done, valid, err, sat, count} !== {5'b00000, {OUT_W{1'b0}}}) begin
         bad++;
         $display("FAIL midreset_outputs got busy=%b done=%b valid=%b err=%b sat=%b count=%0d want all 0",
                  busy, done, valid, err, sat, count);
      end
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL midreset_idle got busy/done activity after reset want none");
      end
   endtask

   task automatic test_back_to_back();
      run_conv(4'd0, 4'd9, 1, 0, 0, 0, "b2b_a");
      run_conv(4'd3, 4'd0, 1, 0, 0, 0, "b2b_b");
      run_conv(4'd1, 4'd13, 1, 0, 0, 0, "b2b_c");
      run_conv(4'd1, 4'd6, 1, 0, 0, 2, "b2b_d");
   endtask

   task automatic test_random();
      logic [3:0] t, u;
      int s_at, s_len, rs;
      for (int i = 0; i < 25; i++) begin
         t = 4'($urandom_range(0, 11));
         u = 4'($urandom_range(0, 11));
         s_at  = $urandom_range(1, int'(t) + 1);
         s_len = $urandom_range(0, 3);
         rs    = $urandom_range(0, 3);
         run_conv(t, u, s_at, s_len, rs, $urandom_range(0, 2), "rand");
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; en = 1'b1; tens = 4'd0; units = 4'd0;
      test_reset();
      test_basic();
      test_range();
      test_invalid();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
